// File: rtl/superh16_mem_bridge_if.sv
// ---------------------------------------------------------------------------
// superh16_mem_bridge_if
//
// Purpose: beat-level backing-bus bundle between the line bridge and the
// memory side. The bridge is the master and issues one beat request per
// handshake. The memory side is the slave and returns read beats through
// bus_rvalid/bus_rdata.
//
// Signals:
//   bus_valid   master -> slave  beat request valid
//   bus_ready   slave  -> master beat request accepted
//   bus_we      master -> slave  beat write enable
//   bus_addr    master -> slave  beat byte address (PADDR_W)
//   bus_wdata   master -> slave  beat write data (BEAT_BYTES*8)
//   bus_rvalid  slave  -> master read beat returned
//   bus_rdata   slave  -> master read beat data (BEAT_BYTES*8)
// ---------------------------------------------------------------------------
interface superh16_mem_bridge_if #(
    parameter int PADDR_W    = 56,
    parameter int BEAT_BYTES = 8
);
    logic                    bus_valid;
    logic                    bus_ready;
    logic                    bus_we;
    logic [PADDR_W-1:0]      bus_addr;
    logic [BEAT_BYTES*8-1:0] bus_wdata;
    logic                    bus_rvalid;
    logic [BEAT_BYTES*8-1:0] bus_rdata;

    modport master (
        output bus_valid,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_ready,
        input  bus_rvalid,
        input  bus_rdata
    );

    modport slave (
        input  bus_valid,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_ready,
        output bus_rvalid,
        output bus_rdata
    );
endinterface

// File: rtl/superh16_mem_bridge.sv
// ---------------------------------------------------------------------------
// superh16_mem_bridge
//
// Purpose: converts a core cache-line request (one LINE_BYTES read or write)
// into NBEATS sequential BEAT_BYTES beats on the backing bus. Read beats are
// assembled into mem_rdata. mem_ack is returned once per completed line.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   mem_req       core line request, held high until mem_ack
//   mem_addr      core request address; the line offset bits are dropped
//   mem_we        1 = line write, 0 = line read
//   mem_wdata     write line
//   mem_ack       one-cycle completion pulse
//   mem_rdata     last read line; it changes only while read beats are captured
//   bus           backing-bus master modport (see superh16_mem_bridge_if)
//   busy          high whenever the FSM is not IDLE
//   err_spurious  sticky flag for a read beat that was not expected
//   txn_count     completed transactions, wraps at 2^32
//
// Timing note: mem_ack is registered from the ACK state. It is therefore high
// in the cycle after ACK, which is also the cycle where txn_count shows the new
// value. In the fastest case the request is sampled at edge 0 and mem_ack is
// high after edge NBEATS+1.
// ---------------------------------------------------------------------------
module superh16_mem_bridge #(
    parameter int LINE_BYTES = 64,
    parameter int PADDR_W    = 56,
    parameter int BEAT_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_req,
    input  logic [PADDR_W-1:0]      mem_addr,
    input  logic                    mem_we,
    input  logic [LINE_BYTES*8-1:0] mem_wdata,
    output logic                    mem_ack,
    output logic [LINE_BYTES*8-1:0] mem_rdata,
    superh16_mem_bridge_if.master   bus,
    output logic                    busy,
    output logic                    err_spurious,
    output logic [31:0]             txn_count
);

    localparam int NBEATS = LINE_BYTES / BEAT_BYTES;
    localparam int BEAT_W = BEAT_BYTES * 8;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int CNT_W  = $clog2(NBEATS + 1);
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(NBEATS - 1);
    localparam logic [CNT_W-1:0]   ALL_BEATS = CNT_W'(NBEATS);
    localparam logic [PADDR_W-1:0] LINE_MASK = ~(PADDR_W'(LINE_BYTES - 1));

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAITR,
        ACK,
        DROP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   ic;
    logic [CNT_W-1:0]   rc;
    logic [CNT_W-1:0]   rc_nxt;
    logic [PADDR_W-1:0] line_base;
    logic               we_q;
    logic [LINE_W-1:0]  wdata_q;
    logic               issue_hs;
    logic               rbeat_ok;
    logic               rbeat_bad;

    // bus_valid is high exactly when the state is ISSUE, so a handshake is
    // ISSUE plus bus_ready. A read beat is taken only while this read can
    // still use it. Any other rvalid counts as spurious.
    assign issue_hs  = (state == ISSUE) && bus.bus_ready;
    assign rbeat_ok  = bus.bus_rvalid && ((state == ISSUE) || (state == WAITR))
                       && !we_q && (rc != ALL_BEATS);
    assign rbeat_bad = bus.bus_rvalid && !rbeat_ok;
    assign rc_nxt    = rc + CNT_W'(rbeat_ok);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read completion uses rc_nxt. A beat that lands in the same cycle as
    // the last request handshake, or the final beat in WAITR, therefore
    // moves the FSM to ACK on that same edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_hs && (ic == LAST_BEAT)) begin
                    if (we_q || (rc_nxt == ALL_BEATS)) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAITR;
                    end
                end
            end
            WAITR: begin
                if (rc_nxt == ALL_BEATS) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = DROP;
            end
            DROP: begin
                if (!mem_req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Beat fields come only from registers, so they stay stable during a stall.
    always_comb begin
        bus.bus_valid = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        if (state == ISSUE) begin
            bus.bus_valid = 1'b1;
            bus.bus_we    = we_q;
            bus.bus_addr  = line_base + (PADDR_W'(ic) * PADDR_W'(BEAT_BYTES));
            bus.bus_wdata = wdata_q[ic[IDX_W-1:0]*BEAT_W +: BEAT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_base    <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            ic           <= '0;
            rc           <= '0;
            mem_rdata    <= '0;
            mem_ack      <= 1'b0;
            txn_count    <= '0;
            err_spurious <= 1'b0;
        end else begin
            mem_ack <= (state == ACK);
            if (state == ACK) begin
                txn_count <= txn_count + 32'd1;
            end
            if (rbeat_bad) begin
                err_spurious <= 1'b1;
            end
            if ((state == IDLE) && mem_req) begin
                line_base <= mem_addr & LINE_MASK;
                we_q      <= mem_we;
                wdata_q   <= mem_wdata;
                ic        <= '0;
                rc        <= '0;
            end else begin
                if (issue_hs) begin
                    ic <= ic + CNT_W'(1);
                end
                if (rbeat_ok) begin
                    mem_rdata[rc[IDX_W-1:0]*BEAT_W +: BEAT_W] <= bus.bus_rdata;
                    rc <= rc_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_superh16_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_superh16_mem_bridge
//
// Purpose: scoreboard bench for superh16_mem_bridge. Each stimulus call queues
// the beats it expects on the bus and the line/count it expects at mem_ack.
// A negedge monitor compares these against what the DUT presents. A memory
// responder drives bus_ready/bus_rvalid in the selected mode.
// ---------------------------------------------------------------------------
module tb_superh16_mem_bridge;

    localparam int PADDR_W = 56;
    localparam int NB      = 8;

    typedef struct {
        logic [PADDR_W-1:0] addr;
        logic               we;
        logic [63:0]        wdata;
    } beat_t;

    typedef struct {
        logic [511:0] rdata;
        logic [31:0]  txn;
        int           lat_mode;
    } ack_t;

    logic               clk;
    logic               rst_n;
    logic               mem_req;
    logic [PADDR_W-1:0] mem_addr;
    logic               mem_we;
    logic [511:0]       mem_wdata;
    logic               mem_ack;
    logic [511:0]       mem_rdata;
    logic               busy;
    logic               err_spurious;
    logic [31:0]        txn_count;

    logic               resp_ready;
    logic               resp_rvalid;
    logic [63:0]        resp_rdata;
    logic               inj_rvalid;
    logic [63:0]        inj_rdata;

    int                 ready_mode;
    int                 rvalid_mode;
    logic [63:0]        rbeat [NB];

    beat_t              exp_beats[$];
    ack_t               exp_acks[$];
    logic [511:0]       model_rdata;
    logic [31:0]        model_txn;

    int                 n_checks;
    int                 n_errors;
    int                 cyc;
    int                 req_cyc;
    int                 last_rv_cyc;

    superh16_mem_bridge_if #(.PADDR_W(PADDR_W), .BEAT_BYTES(8)) bif ();

    assign bif.bus_ready  = resp_ready;
    assign bif.bus_rvalid = resp_rvalid | inj_rvalid;
    assign bif.bus_rdata  = inj_rvalid ? inj_rdata : resp_rdata;

    superh16_mem_bridge #(
        .LINE_BYTES(64),
        .PADDR_W   (PADDR_W),
        .BEAT_BYTES(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .bus         (bif),
        .busy        (busy),
        .err_spurious(err_spurious),
        .txn_count   (txn_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic resetChecks();
        checkOutput("rst_mem_ack",   512'(mem_ack), 512'(0));
        checkOutput("rst_busy",      512'(busy), 512'(0));
        checkOutput("rst_bus_valid", 512'(bif.bus_valid), 512'(0));
        checkOutput("rst_bus_we",    512'(bif.bus_we), 512'(0));
        checkOutput("rst_bus_addr",  512'(bif.bus_addr), 512'(0));
        checkOutput("rst_bus_wdata", 512'(bif.bus_wdata), 512'(0));
        checkOutput("rst_mem_rdata", mem_rdata, 512'(0));
        checkOutput("rst_err",       512'(err_spurious), 512'(0));
        checkOutput("rst_txn",       512'(txn_count), 512'(0));
    endtask

    // The memory side answers beats for the core request currently in flight.
    // In mode 0 each read beat returns in the same cycle as its handshake.
    // In mode 1 all read beats return back to back, about 20 cycles after the
    // last handshake.
    initial begin : responder
        int  hs_cnt;
        int  rv_cnt;
        int  dly;
        bit  hs;
        resp_ready  = 1'b0;
        resp_rvalid = 1'b0;
        resp_rdata  = '0;
        hs_cnt = 0;
        rv_cnt = 0;
        dly    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) resp_ready = !resp_ready;
            else                 resp_ready = 1'b1;
            resp_rvalid = 1'b0;
            if (!rst_n || !busy) begin
                hs_cnt = 0;
                rv_cnt = 0;
                dly    = 0;
            end else begin
                hs = bif.bus_valid && resp_ready;
                if (rvalid_mode == 0) begin
                    if (hs && !bif.bus_we && hs_cnt < NB) begin
                        resp_rvalid = 1'b1;
                        resp_rdata  = rbeat[hs_cnt];
                    end
                end else if (hs_cnt == NB && rv_cnt < NB) begin
                    if (dly < 19) begin
                        dly++;
                    end else begin
                        resp_rvalid = 1'b1;
                        resp_rdata  = rbeat[rv_cnt];
                        rv_cnt++;
                    end
                end
                if (hs) hs_cnt++;
            end
        end
    end

    // On every cycle where bus_valid is high, compare the presented beat
    // against the head of the expected queue. The head is popped only on a
    // handshake, so a stalled beat is checked again each cycle.
    always @(negedge clk) begin : monitor
        beat_t b;
        ack_t  a;
        cyc++;
        if (rst_n) begin
            if (mem_req && !busy) req_cyc = cyc;
            if (bif.bus_rvalid) last_rv_cyc = cyc;
            if (bif.bus_valid) begin
                if (exp_beats.size() == 0) begin
                    checkOutput("unexpected_beat", 512'(bif.bus_valid), 512'(0));
                end else begin
                    b = exp_beats[0];
                    checkOutput("beat_addr",  512'(bif.bus_addr), 512'(b.addr));
                    checkOutput("beat_we",    512'(bif.bus_we), 512'(b.we));
                    checkOutput("beat_wdata", 512'(bif.bus_wdata), 512'(b.wdata));
                    if (bif.bus_ready) void'(exp_beats.pop_front());
                end
            end
            if (mem_ack) begin
                if (exp_acks.size() == 0) begin
                    checkOutput("unexpected_ack", 512'(mem_ack), 512'(0));
                end else begin
                    a = exp_acks.pop_front();
                    checkOutput("ack_rdata", mem_rdata, a.rdata);
                    checkOutput("ack_txn", 512'(txn_count), 512'(a.txn));
                    checkOutput("ack_beats_done", 512'(exp_beats.size()), 512'(0));
                    if (a.lat_mode == 1)
                        checkOutput("ack_latency_req", 512'(cyc - req_cyc), 512'(NB + 2));
                    else if (a.lat_mode == 2)
                        checkOutput("ack_latency_rvalid", 512'(cyc - last_rv_cyc), 512'(2));
                end
            end
        end
    end

    // lat_mode: 0 = no latency check, 1 = measured from the request capture,
    // 2 = measured from the last read beat. If probe_at > 0, the bench checks
    // the WAITR signature on that cycle.
    task automatic applyStimulus(input logic we, input logic [PADDR_W-1:0] addr,
                                 input logic [511:0] wline, input int rmode, input int vmode,
                                 input int hold, input int lat_mode, input int probe_at);
        beat_t              b;
        ack_t               a;
        logic [PADDR_W-1:0] base;
        bit                 got;
        base = addr & ~(PADDR_W'(63));
        for (int i = 0; i < NB; i++) begin
            b.addr  = base + PADDR_W'(8 * i);
            b.we    = we;
            b.wdata = wline[i*64 +: 64];
            exp_beats.push_back(b);
        end
        if (!we) begin
            for (int i = 0; i < NB; i++) model_rdata[i*64 +: 64] = rbeat[i];
        end
        model_txn  = model_txn + 32'd1;
        a.rdata    = model_rdata;
        a.txn      = model_txn;
        a.lat_mode = lat_mode;
        exp_acks.push_back(a);
        ready_mode  = rmode;
        rvalid_mode = vmode;
        @(posedge clk);
        #1;
        mem_addr  = addr;
        mem_we    = we;
        mem_wdata = wline;
        mem_req   = 1'b1;
        got = 1'b0;
        for (int k = 1; k <= 300 && !got; k++) begin
            @(negedge clk);
            if (probe_at == k) begin
                checkOutput("waitr_busy",     512'(busy), 512'(1));
                checkOutput("waitr_no_valid", 512'(bif.bus_valid), 512'(0));
                checkOutput("waitr_no_ack",   512'(mem_ack), 512'(0));
            end
            if (mem_ack) got = 1'b1;
        end
        if (!got) begin
            checkOutput("ack_timeout", 512'(got), 512'(1));
            exp_beats.delete();
            exp_acks.delete();
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("drop_busy",     512'(busy), 512'(1));
            checkOutput("drop_no_valid", 512'(bif.bus_valid), 512'(0));
        end
        @(posedge clk);
        #1;
        mem_req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_after_drop", 512'(busy), 512'(0));
    endtask

    initial begin : stimulus
        logic [511:0]       wline;
        logic [PADDR_W-1:0] base;
        beat_t              b;
        n_checks    = 0;
        n_errors    = 0;
        cyc         = 0;
        req_cyc     = 0;
        last_rv_cyc = 0;
        rst_n       = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        inj_rvalid  = 1'b0;
        inj_rdata   = '0;
        ready_mode  = 0;
        rvalid_mode = 0;
        model_rdata = '0;
        model_txn   = '0;
        for (int i = 0; i < NB; i++) rbeat[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        resetChecks();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] read 0x80000027, full speed");
        for (int i = 0; i < NB; i++) rbeat[i] = 64'(i);
        applyStimulus(1'b0, 56'h00_0000_8000_0027, '0, 0, 0, 0, 1, 0);

        $display("[TB] write with bus_ready toggling");
        for (int i = 0; i < NB; i++)
            wline[i*64 +: 64] = {32'hC0DE_0000 + 32'(i), 32'hFACE_0000 + 32'(i)};
        applyStimulus(1'b1, 56'hAB_CDEF_0123_4567, wline, 1, 0, 0, 0, 0);

        $display("[TB] read with delayed rvalid");
        for (int i = 0; i < NB; i++) rbeat[i] = 64'hD000_0000_0000_0000 + 64'(i * 32'h0001_0101);
        applyStimulus(1'b0, 56'h00_0000_0001_0FC8, '0, 0, 1, 0, 2, 20);

        $display("[TB] read with mem_req held after ack, then a fresh write");
        for (int i = 0; i < NB; i++) rbeat[i] = 64'hF0F0_0000_0000_0000 | 64'(i << 8);
        applyStimulus(1'b0, 56'h00_0000_2000_0008, '0, 0, 0, 5, 1, 0);
        applyStimulus(1'b1, 56'h00_0000_3000_0000, ~wline, 0, 0, 0, 1, 0);

        $display("[TB] spurious rvalid in IDLE");
        @(posedge clk);
        #1;
        inj_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
        inj_rvalid = 1'b1;
        @(posedge clk);
        #1;
        inj_rvalid = 1'b0;
        checkOutput("err_set", 512'(err_spurious), 512'(1));
        repeat (5) @(posedge clk);
        #1;
        checkOutput("err_sticky", 512'(err_spurious), 512'(1));
        checkOutput("rdata_after_spurious", mem_rdata, model_rdata);
        checkOutput("idle_after_spurious", 512'(busy), 512'(0));

        $display("[TB] reset after three read beats");
        for (int i = 0; i < NB; i++) rbeat[i] = 64'h5A00_0000_0000_0000 + 64'(i);
        base = 56'h00_0000_4000_0040;
        for (int i = 0; i < NB; i++) begin
            b.addr  = base + PADDR_W'(8 * i);
            b.we    = 1'b0;
            b.wdata = '0;
            exp_beats.push_back(b);
        end
        ready_mode  = 0;
        rvalid_mode = 0;
        @(posedge clk);
        #1;
        mem_addr  = base;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_req   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("partial_rdata", 512'(mem_rdata[191:0]), 512'({rbeat[2], rbeat[1], rbeat[0]}));
        #1;
        rst_n   = 1'b0;
        mem_req = 1'b0;
        #1;
        resetChecks();
        exp_beats.delete();
        model_txn   = '0;
        model_rdata = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 56'h00_0000_4000_0040, '0, 0, 0, 0, 1, 0);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("beats_drained", 512'(exp_beats.size()), 512'(0));
        checkOutput("acks_drained", 512'(exp_acks.size()), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
